// File: rtl/gap_junction_pkg.sv
// Shared types and constants for the GapJunction input-stream generator.
package gap_junction_pkg;

  localparam int          AXIS_DATA_W       = 32;
  localparam int unsigned DEFAULT_FRAME_LEN = 216;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SEND,
    ST_GAP,
    ST_DONE,
    ST_DONE_TO
  } state_t;

endpackage

// File: rtl/gap_junction_pattern_gen.sv
// Word/frame index counters for the stimulus pattern; always points at the
// next word to be loaded into the stream output register.
module gap_junction_pattern_gen
  import gap_junction_pkg::*;
#(
  parameter int unsigned            Frame_Length = DEFAULT_FRAME_LEN,
  parameter logic [AXIS_DATA_W-1:0] Data_Base    = 32'd12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   advance,
  input  logic                   clear,
  output logic [AXIS_DATA_W-1:0] data,
  output logic                   last,
  output logic [31:0]            frame_idx
);

  localparam logic [15:0]            LAST_IDX   = 16'(Frame_Length - 1);
  localparam logic [AXIS_DATA_W-1:0] FRAME_STEP = AXIS_DATA_W'(Frame_Length);

  logic [15:0]            word_idx;
  logic [AXIS_DATA_W-1:0] frame_base;

  // frame_base tracks Data_Base + frame_idx*Frame_Length incrementally, so
  // no multiplier is needed and the value wraps mod 2^32 on its own.
  assign last = (word_idx == LAST_IDX);
  assign data = frame_base + {16'd0, word_idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_idx   <= '0;
      frame_idx  <= '0;
      frame_base <= Data_Base;
    end else if (advance) begin
      if (last) begin
        word_idx   <= '0;
        frame_idx  <= frame_idx + 32'd1;
        frame_base <= frame_base + FRAME_STEP;
      end else begin
        word_idx <= word_idx + 16'd1;
      end
    end else if (clear) begin
      word_idx   <= '0;
      frame_idx  <= '0;
      frame_base <= Data_Base;
    end
  end

endmodule

// File: rtl/gap_junction_stimulus_gen.sv
// AXI4-Stream master feeding fixed-length, patterned frames into the
// GapJunction core, with start delay, inter-frame gap and stall watchdog.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_WAIT    | start delay after reset, counts only while enable=1
//   ST_SEND    | TVALID high, one word per handshake
//   ST_GAP     | idle between frames; leaves when gap expired and enable=1
//   ST_DONE    | all frames sent, Done=1 until reset
//   ST_DONE_TO | watchdog fired, Timeout=1 until reset
module gap_junction_stimulus_gen
  import gap_junction_pkg::*;
#(
  parameter int unsigned            Frame_Length       = DEFAULT_FRAME_LEN,
  parameter int unsigned            Num_Frames         = 8,
  parameter int unsigned            Start_Delay        = 20,
  parameter int unsigned            Gap_Cycles         = 4,
  parameter logic [AXIS_DATA_W-1:0] Data_Base          = 32'd12,
  parameter logic [19:0]            Stop_Counter_Value = 20'd20000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   input_r_TVALID_0,
  output logic                   input_r_TLAST_0,
  output logic [AXIS_DATA_W-1:0] input_r_TDATA_0,
  input  logic                   input_r_TREADY_0,
  output logic [15:0]            Frame_Counter,
  output logic                   Done,
  output logic                   Timeout
);

  state_t                 state_q, state_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [AXIS_DATA_W-1:0] tdata_q, tdata_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic [31:0]            wait_cnt_q, wait_cnt_d;
  logic [31:0]            gap_cnt_q, gap_cnt_d;
  logic [19:0]            stall_cnt_q, stall_cnt_d;

  logic                   load;
  logic                   pg_clear;
  logic [AXIS_DATA_W-1:0] pg_data;
  logic                   pg_last;
  logic [31:0]            pg_frame_idx;
  logic                   handshake;

  gap_junction_pattern_gen #(
    .Frame_Length (Frame_Length),
    .Data_Base    (Data_Base)
  ) u_pattern (
    .clk       (clk),
    .reset     (reset),
    .advance   (load),
    .clear     (pg_clear),
    .data      (pg_data),
    .last      (pg_last),
    .frame_idx (pg_frame_idx)
  );

  assign handshake = tvalid_q && input_r_TREADY_0;

  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stall_cnt_d = stall_cnt_q;
    load        = 1'b0;
    pg_clear    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        pg_clear = 1'b1;
        if (enable) begin
          if (wait_cnt_q == Start_Delay) begin
            load     = 1'b1;
            tvalid_d = 1'b1;
            state_d  = ST_SEND;
          end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
          end
        end
      end

      ST_SEND: begin
        // pg_frame_idx has already stepped past the frame whose last word
        // is on the bus, so it equals the completed-frame count here.
        if (handshake) begin
          stall_cnt_d = '0;
          if (tlast_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (Num_Frames != 0 && pg_frame_idx == Num_Frames) begin
              tvalid_d = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_DONE;
            end else if (Gap_Cycles != 0 || !enable) begin
              tvalid_d  = 1'b0;
              gap_cnt_d = 32'd1;
              state_d   = ST_GAP;
            end else begin
              load = 1'b1;
            end
          end else begin
            load = 1'b1;
          end
        end else if (stall_cnt_q == Stop_Counter_Value - 20'd1) begin
          tvalid_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE_TO;
        end else begin
          stall_cnt_d = stall_cnt_q + 20'd1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q >= Gap_Cycles) begin
          if (enable) begin
            load     = 1'b1;
            tvalid_d = 1'b1;
            state_d  = ST_SEND;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end

      ST_DONE, ST_DONE_TO: ;

      default: state_d = ST_WAIT;
    endcase

    if (load) begin
      tdata_d = pg_data;
      tlast_d = pg_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_WAIT;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign input_r_TVALID_0 = tvalid_q;
  assign input_r_TLAST_0  = tlast_q;
  assign input_r_TDATA_0  = tdata_q;
  assign Frame_Counter    = frame_cnt_q;
  assign Done             = done_q;
  assign Timeout          = timeout_q;

endmodule
